// File: rtl/trainerror_hs_responder.sv
// Responder side of the TRAINERROR sideband handshake: accepts a partner ENTRY_REQ,
// waits for the LTSM to enter TRAINERROR, then answers with ENTRY_RESP.
module trainerror_hs_responder #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_trainerror_en,
    input  logic                    i_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_Rx_SbMessage,
    input  logic                    i_falling_edge_busy,
    output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
    output logic                    o_valid_Partner,
    output logic                    o_partner_valid,
    output logic                    o_req_detected,
    output logic                    o_trainerror_end_Partner,
    output logic                    o_timeout
);

    localparam logic [SB_MSG_WIDTH-1:0] MSG_REQ  = SB_MSG_WIDTH'(4'hF);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_RESP = SB_MSG_WIDTH'(4'hE);
    localparam logic [TO_W-1:0]         TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_EN   = 3'd1,
        SEND_RESP = 3'd2,
        DONE      = 3'd3,
        TIMEOUT   = 3'd4
    } state_e;

    state_e                  cs_q, ns_d;
    logic [TO_W-1:0]         cnt_q, cnt_d;
    logic [SB_MSG_WIDTH-1:0] tx_q;
    logic                    valid_q, pv_q, req_q, end_q, to_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_q  <= IDLE;
            cnt_q <= '0;
        end else begin
            cs_q  <= ns_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        ns_d = cs_q;
        case (cs_q)
            IDLE:      if (i_msg_valid && i_Rx_SbMessage == MSG_REQ) ns_d = WAIT_EN;
            // Enable is checked before expiry so a late LTSM entry still gets answered.
            WAIT_EN:   if (i_trainerror_en)       ns_d = SEND_RESP;
                       else if (cnt_q == TO_LAST) ns_d = TIMEOUT;
            SEND_RESP: if (!i_trainerror_en)        ns_d = IDLE;
                       else if (i_falling_edge_busy) ns_d = DONE;
            DONE:      if (!i_trainerror_en)        ns_d = IDLE;
            TIMEOUT:   ns_d = IDLE;
            default:   ns_d = IDLE;
        endcase
    end

    // Counter only runs across consecutive WAIT_EN cycles; entry and any other state clear it.
    always_comb begin
        cnt_d = '0;
        if (cs_q == WAIT_EN && ns_d == WAIT_EN) cnt_d = cnt_q + TO_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_q    <= '0;
            valid_q <= 1'b0;
            pv_q    <= 1'b0;
            req_q   <= 1'b0;
            end_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            tx_q    <= (ns_d == SEND_RESP) ? MSG_RESP : '0;
            valid_q <= (ns_d == SEND_RESP);
            pv_q    <= (ns_d == WAIT_EN) || (ns_d == SEND_RESP) || (ns_d == DONE);
            req_q   <= (cs_q == IDLE) && (ns_d == WAIT_EN);
            end_q   <= (ns_d == DONE);
            to_q    <= (ns_d == TIMEOUT);
        end
    end

    assign o_TX_SbMessage           = tx_q;
    assign o_valid_Partner          = valid_q;
    assign o_partner_valid          = pv_q;
    assign o_req_detected           = req_q;
    assign o_trainerror_end_Partner = end_q;
    assign o_timeout                = to_q;

endmodule

// File: tb/tb_trainerror_hs_responder.sv
// Bench for trainerror_hs_responder: directed handshake scenarios plus a random
// run, all compared against a handshake-level reference model.
module tb_trainerror_hs_responder;

    localparam int TO = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_trainerror_en = 1'b0;
    logic       i_msg_valid = 1'b0;
    logic [3:0] i_Rx_SbMessage = 4'h0;
    logic       i_falling_edge_busy = 1'b0;
    logic [3:0] o_TX_SbMessage;
    logic       o_valid_Partner, o_partner_valid, o_req_detected;
    logic       o_trainerror_end_Partner, o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which phase of the handshake the partner flow is in.
    bit m_waiting, m_sending, m_finished, m_expired, m_new_req;
    int m_waited;

    trainerror_hs_responder #(.SB_MSG_WIDTH(4), .TIMEOUT_CYCLES(TO), .TO_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_trainerror_en(i_trainerror_en),
        .i_msg_valid(i_msg_valid), .i_Rx_SbMessage(i_Rx_SbMessage),
        .i_falling_edge_busy(i_falling_edge_busy),
        .o_TX_SbMessage(o_TX_SbMessage), .o_valid_Partner(o_valid_Partner),
        .o_partner_valid(o_partner_valid), .o_req_detected(o_req_detected),
        .o_trainerror_end_Partner(o_trainerror_end_Partner), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [8:0] dut_vec();
        return {o_TX_SbMessage, o_valid_Partner, o_partner_valid, o_req_detected,
                o_trainerror_end_Partner, o_timeout};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_sending ? 4'hE : 4'h0, m_sending, m_waiting | m_sending | m_finished,
                m_new_req, m_finished, m_expired};
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_sending = 0; m_finished = 0; m_expired = 0; m_new_req = 0;
        m_waited = 0;
    endtask

    // Advance one clock: the model consumes the inputs seen at the edge, and the
    // task returns on the following falling edge where outputs are compared.
    task automatic step();
        @(posedge i_clk);
        if (i_rst_n) begin
            m_new_req = 0;
            if (m_expired) m_expired = 0;
            else if (!m_waiting && !m_sending && !m_finished) begin
                if (i_msg_valid && i_Rx_SbMessage == 4'hF) begin
                    m_waiting = 1; m_waited = 1; m_new_req = 1;
                end
            end else if (m_waiting) begin
                if (i_trainerror_en) begin m_waiting = 0; m_sending = 1; end
                else if (m_waited == TO) begin m_waiting = 0; m_expired = 1; end
                else m_waited++;
            end else if (m_sending) begin
                if (!i_trainerror_en) m_sending = 0;
                else if (i_falling_edge_busy) begin m_sending = 0; m_finished = 1; end
            end else if (!i_trainerror_en) m_finished = 0;
        end
        @(negedge i_clk);
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst_n = 0; i_trainerror_en = 0; i_msg_valid = 0; i_Rx_SbMessage = 0;
        i_falling_edge_busy = 0;
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst_n = 0; i_msg_valid = 1; i_Rx_SbMessage = 4'hF; i_trainerror_en = 0;
        model_reset();
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (dut_vec() !== 9'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), 9'h0);
        end
        i_rst_n = 1;
        step();
        n_checks++;
        if (o_partner_valid !== 1'b1 || o_req_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_req: pv=%b req=%b want 1 1", o_partner_valid, o_req_detected);
        end
        i_msg_valid = 0;
        step();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_after_req: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_normal();
        apply_reset();
        i_msg_valid = 1; i_Rx_SbMessage = 4'hF;
        step();
        i_msg_valid = 0;
        n_checks++;
        if (o_req_detected !== 1'b1 || o_partner_valid !== 1'b1 || o_valid_Partner !== 1'b0) begin
            n_fail++; $display("FAIL normal_req_det: got %h want req=1 pv=1 valid=0", dut_vec());
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec() || o_valid_Partner !== 1'b0) begin
                n_fail++; $display("FAIL normal_wait: got %h want %h", dut_vec(), exp_vec());
            end
        end
        i_trainerror_en = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (o_TX_SbMessage !== 4'hE || o_valid_Partner !== 1'b1 || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL normal_resp: got %h want %h", dut_vec(), exp_vec());
            end
        end
        i_falling_edge_busy = 1;
        step();
        i_falling_edge_busy = 0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_trainerror_end_Partner !== 1'b1 || o_valid_Partner !== 1'b0 || o_TX_SbMessage !== 4'h0) begin
                n_fail++; $display("FAIL normal_done: got %h want end=1 valid=0", dut_vec());
            end
            step();
        end
        i_trainerror_en = 0;
        step();
        n_checks++;
        if (dut_vec() !== 9'h0) begin
            n_fail++; $display("FAIL normal_exit: got %h want %h", dut_vec(), 9'h0);
        end
    endtask

    task automatic test_timeout();
        int pv_cycles, to_pulses;
        apply_reset();
        i_msg_valid = 1; i_Rx_SbMessage = 4'hF;
        step();
        i_msg_valid = 0;
        pv_cycles = 1; to_pulses = 0;
        for (int k = 0; k < 3 * TO; k++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL timeout_track: cyc %0d got %h want %h", k, dut_vec(), exp_vec());
            end
            if (o_timeout) to_pulses++;
            else if (o_partner_valid) pv_cycles++;
        end
        n_checks++;
        if (pv_cycles !== TO) begin
            n_fail++; $display("FAIL timeout_wait_len: got %0d want %0d", pv_cycles, TO);
        end
        n_checks++;
        if (to_pulses !== 1) begin
            n_fail++; $display("FAIL timeout_pulses: got %0d want 1", to_pulses);
        end
    endtask

    task automatic test_edge();
        int to_seen;
        apply_reset();
        i_msg_valid = 1; i_Rx_SbMessage = 4'hF;
        step();
        i_msg_valid = 0;
        to_seen = 0;
        for (int k = 1; k < TO; k++) begin
            step();
            if (o_timeout) to_seen++;
        end
        i_trainerror_en = 1;
        step();
        n_checks++;
        if (o_valid_Partner !== 1'b1 || o_TX_SbMessage !== 4'hE || o_timeout !== 1'b0) begin
            n_fail++; $display("FAIL edge_en_wins: got %h want valid=1 tx=E to=0", dut_vec());
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (o_timeout) to_seen++;
        end
        n_checks++;
        if (to_seen !== 0) begin
            n_fail++; $display("FAIL edge_no_timeout: got %0d pulses want 0", to_seen);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        i_trainerror_en = 1; i_msg_valid = 1; i_Rx_SbMessage = 4'hF;
        step();
        i_msg_valid = 0;
        step();
        n_checks++;
        if (o_valid_Partner !== 1'b1 || o_TX_SbMessage !== 4'hE) begin
            n_fail++; $display("FAIL crossing_resp: got %h want valid=1 tx=E", dut_vec());
        end
        i_trainerror_en = 0;
        step();
        n_checks++;
        if (dut_vec() !== 9'h0) begin
            n_fail++; $display("FAIL abort_en_drop: got %h want %h", dut_vec(), 9'h0);
        end
        i_msg_valid = 1;
        step();
        i_msg_valid = 0;
        step();
        #2 i_rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== 9'h0) begin
            n_fail++; $display("FAIL abort_async_reset: got %h want %h", dut_vec(), 9'h0);
        end
        @(negedge i_clk);
        i_rst_n = 1;
        step();
        n_checks++;
        if (dut_vec() !== 9'h0) begin
            n_fail++; $display("FAIL abort_no_retain: got %h want %h", dut_vec(), 9'h0);
        end
    endtask

    task automatic test_filter();
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            i_msg_valid    = (k % 2 == 0);
            i_Rx_SbMessage = i_msg_valid ? 4'($urandom_range(0, 14)) : 4'hF;
            step();
            n_checks++;
            if (o_partner_valid !== 1'b0 || o_valid_Partner !== 1'b0) begin
                n_fail++; $display("FAIL filter_idle: rx=%h got %h want 0", i_Rx_SbMessage, dut_vec());
            end
        end
        i_trainerror_en = 1; i_msg_valid = 1; i_Rx_SbMessage = 4'hF;
        step();
        i_msg_valid = 0;
        step();
        i_falling_edge_busy = 1;
        step();
        i_falling_edge_busy = 0;
        i_msg_valid = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (o_req_detected !== 1'b0 || o_valid_Partner !== 1'b0 || o_trainerror_end_Partner !== 1'b1) begin
                n_fail++; $display("FAIL filter_dup_req: got %h want req=0 valid=0 end=1", dut_vec());
            end
        end
        i_msg_valid = 0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            i_msg_valid         = ($urandom_range(0, 9) < 3);
            i_Rx_SbMessage      = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            i_falling_edge_busy = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) i_trainerror_en = ~i_trainerror_en;
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle %0d: got %h want %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_normal();
        test_timeout();
        test_edge();
        test_abort();
        test_filter();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
